// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan monitor: segment/digit indices,
// the hex glyph table and the capture FSM state encoding.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Strobe bit positions: digit1 is the leftmost digit and sits in the MSB.
  localparam int DIG1 = 3;
  localparam int DIG2 = 2;
  localparam int DIG3 = 1;
  localparam int DIG4 = 0;

  // Active-high glyphs in {G,F,E,D,C,B,A} order, indexed by hex code.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [2:0] strobe_count(input logic [3:0] dig_n);
    return 3'($countones(~dig_n));
  endfunction

  function automatic logic [1:0] dig_index(input logic [3:0] dig_n);
    case (dig_n)
      4'b0111: return 2'(DIG1);
      4'b1011: return 2'(DIG2);
      4'b1101: return 2'(DIG3);
      default: return 2'(DIG4);
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse of the display encoder: active-high segment pattern to hex code.
// Patterns outside the 16-glyph table (including all-off) give code 0, bad=1.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);

  logic [6:0] glyph;

  assign glyph = {seg[SEG_G], seg[SEG_F], seg[SEG_E], seg[SEG_D],
                  seg[SEG_C], seg[SEG_B], seg[SEG_A]};

  always_comb begin
    code = 4'h0;
    bad  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (glyph == HEX_TABLE[i]) begin
        code = 4'(i);
        bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the multiplexed 4-digit 7-segment bus: waits for each
// digit to settle, decodes it and publishes whole frames. Define
// SEG_SCAN_DP_CAPTURE_EN to also capture decimal points into dp_mask.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dig_n,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  output logic        frame_valid,
  output logic [15:0] frame_val,
  output logic [3:0]  bad_mask,
`ifdef SEG_SCAN_DP_CAPTURE_EN
  output logic [3:0]  dp_mask,
`endif
  output logic        err_multi,
  output logic        disp_off
);

  localparam logic [7:0]  STABLE_TGT  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_TGT = 16'(TIMEOUT_CYCLES);

  logic [3:0]  dig_p1;
  logic [6:0]  seg_p1;
  state_t      state, state_next;
  logic [3:0]  cur_dig;
  logic [6:0]  cur_seg;
  logic [7:0]  stab_cnt;
  logic [15:0] idle_cnt;
  logic [3:0]  cap_mask;
  logic [15:0] staging_val;
  logic [3:0]  staging_bad;
  logic        legal, illegal, same, timeout, publish;
  logic        load, inc, cap;
  logic [3:0]  dec_code;
  logic        dec_bad;
  logic [1:0]  slot;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic        dp_p1;
  logic        cur_dp;
  logic [3:0]  staging_dp;
`else
  logic        dp_unused;
  assign dp_unused = dp_n;
`endif

  // ---- p1: input register; every decision below uses these copies ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dig_p1 <= 4'hF;
    else     dig_p1 <= dig_n;
  end

  always_ff @(posedge clk) begin
    seg_p1 <= seg_n;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    dp_p1  <= dp_n;
`endif
  end

  // ---- classification and capture FSM ----
  assign legal   = (strobe_count(dig_p1) == 3'd1);
  assign illegal = (strobe_count(dig_p1) >= 3'd2);
  assign timeout = (idle_cnt == TIMEOUT_TGT);
  assign publish = (cap_mask == 4'hF);
`ifdef SEG_SCAN_DP_CAPTURE_EN
  assign same = (dig_p1 == cur_dig) && (seg_p1 == cur_seg) && (dp_p1 == cur_dp);
`else
  assign same = (dig_p1 == cur_dig) && (seg_p1 == cur_seg);
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    inc        = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          load       = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (!legal) begin
          state_next = IDLE;
        end else if (!same) begin
          load = 1'b1;
        end else if (stab_cnt + 8'd1 == STABLE_TGT) begin
          cap        = 1'b1;
          state_next = HOLD;
        end else begin
          inc = 1'b1;
        end
      end
      HOLD: begin
        if (!legal) begin
          state_next = IDLE;
        end else if (!same) begin
          load       = 1'b1;
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  seg7_to_hex u_dec (
    .seg  (~cur_seg),
    .code (dec_code),
    .bad  (dec_bad)
  );

  assign slot = dig_index(cur_dig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_dig     <= 4'hF;
      stab_cnt    <= 8'd0;
      idle_cnt    <= 16'd0;
      cap_mask    <= 4'h0;
      frame_valid <= 1'b0;
      frame_val   <= 16'h0;
      bad_mask    <= 4'h0;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      dp_mask     <= 4'h0;
`endif
      err_multi   <= 1'b0;
      disp_off    <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        cur_dig  <= dig_p1;
        stab_cnt <= 8'd1;
      end else if (inc || cap) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      if (illegal) err_multi <= 1'b1;
      if (legal)         idle_cnt <= 16'd0;
      else if (!timeout) idle_cnt <= idle_cnt + 16'd1;
      if (cap)          disp_off <= 1'b0;
      else if (timeout) disp_off <= 1'b1;
      // ---- p2: frame publication from the staging register ----
      frame_valid <= publish;
      if (publish) begin
        frame_val <= staging_val;
        bad_mask  <= staging_bad;
`ifdef SEG_SCAN_DP_CAPTURE_EN
        dp_mask   <= staging_dp;
`endif
      end
      // A capture in the publish cycle belongs to the next frame.
      if (timeout) cap_mask <= 4'h0;
      else         cap_mask <= (publish ? 4'h0 : cap_mask) | (cap ? ~cur_dig : 4'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cur_seg <= seg_p1;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      cur_dp  <= dp_p1;
`endif
    end
    if (cap) begin
      staging_val[4*slot +: 4] <= dec_code;
      staging_bad[slot]        <= dec_bad;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      staging_dp[slot]         <= ~cur_dp;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-frame scans plus
// hand-written sequences for settling, latency, errors, timeout and reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dig_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_valid;
  logic [15:0] frame_val;
  logic [3:0]  bad_mask;
  logic [3:0]  dp_mask;
  logic        err_multi;
  logic        disp_off;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .dig_n       (dig_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_valid (frame_valid),
    .frame_val   (frame_val),
    .bad_mask    (bad_mask),
`ifdef SEG_SCAN_DP_CAPTURE_EN
    .dp_mask     (dp_mask),
`endif
    .err_multi   (err_multi),
    .disp_off    (disp_off)
  );

`ifndef SEG_SCAN_DP_CAPTURE_EN
  assign dp_mask = 4'h0;
`endif

  always @(negedge clk) if (frame_valid === 1'b1) pulses++;

  typedef struct packed {
    logic [27:0] segs;
    logic [3:0]  dp;
    logic [15:0] exp_val;
    logic [3:0]  exp_bad;
    logic [3:0]  exp_dp;
  } vec_t;

  function automatic logic [6:0] enc(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // digit d is 1..4 (1 = leftmost); seg is active-high
  task automatic drive(input int d, input logic [6:0] seg, input logic dp, input int n);
    dig_n = ~(4'b1000 >> (d - 1));
    seg_n = ~seg;
    dp_n  = ~dp;
    step(n);
  endtask

  task automatic blank(input int n);
    dig_n = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    step(n);
  endtask

  task automatic scan(input logic [27:0] segs, input logic [3:0] dp);
    for (int d = 0; d < 4; d++) drive(d + 1, segs[27 - 7*d -: 7], dp[3 - d], 8);
    blank(2);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{{enc(4'h3), enc(4'h0), enc(4'h1), enc(4'h7)}, 4'b0000, 16'h3017, 4'b0000, 4'b0000};
    vecs[1] = '{{enc(4'h5), enc(4'h5), enc(4'h5), enc(4'h5)}, 4'b1000, 16'h5555, 4'b0000, 4'b1000};
    vecs[2] = '{{enc(4'hA), enc(4'hB), enc(4'hC), enc(4'hD)}, 4'b0101, 16'hABCD, 4'b0000, 4'b0101};
    vecs[3] = '{{enc(4'hE), enc(4'hF), enc(4'h8), enc(4'h9)}, 4'b0000, 16'hEF89, 4'b0000, 4'b0000};
    vecs[4] = '{{enc(4'h1), enc(4'h2), 7'h49,     enc(4'h4)}, 4'b0000, 16'h1204, 4'b0010, 4'b0000};
    vecs[5] = '{{enc(4'h6), enc(4'h7), enc(4'h8), 7'h00},     4'b0000, 16'h6780, 4'b0001, 4'b0000};

    rst   = 1'b1;
    dig_n = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    step(3);
    check("rst frame_valid", 32'(frame_valid), 32'd0);
    check("rst frame_val", 32'(frame_val), 32'h0);
    check("rst bad_mask", 32'(bad_mask), 32'h0);
    check("rst err_multi", 32'(err_multi), 32'd0);
    check("rst disp_off", 32'(disp_off), 32'd0);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      scan(vecs[i].segs, vecs[i].dp);
      check($sformatf("vec%0d pulses", i), 32'(pulses - p0), 32'd1);
      check($sformatf("vec%0d frame_val", i), 32'(frame_val), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d bad_mask", i), 32'(bad_mask), 32'(vecs[i].exp_bad));
`ifdef SEG_SCAN_DP_CAPTURE_EN
      check($sformatf("vec%0d dp_mask", i), 32'(dp_mask), 32'(vecs[i].exp_dp));
`endif
    end
    check("err_multi clean", 32'(err_multi), 32'd0);

    // latency: 4th digit captured 5 cycles in, frame_valid one cycle later
    drive(1, enc(4'h1), 1'b0, 8);
    drive(2, enc(4'h2), 1'b0, 8);
    drive(3, enc(4'h3), 1'b0, 8);
    dig_n = 4'b1110;
    seg_n = ~enc(4'h4);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check($sformatf("latency k=%0d", k), 32'(frame_valid), 32'(k == 6));
    end
    blank(2);
    check("latency frame_val", 32'(frame_val), 32'h1234);

    // digit2 flickers every 2 cycles: no capture, no frame until it holds
    p0 = pulses;
    drive(1, enc(4'h1), 1'b0, 8);
    for (int k = 0; k < 5; k++) drive(2, (k % 2 == 0) ? enc(4'h2) : enc(4'h8), 1'b0, 2);
    drive(3, enc(4'h3), 1'b0, 8);
    drive(4, enc(4'h4), 1'b0, 8);
    check("flicker no frame", 32'(pulses - p0), 32'd0);
    drive(2, enc(4'h8), 1'b0, 8);
    blank(2);
    check("flicker then frame", 32'(pulses - p0), 32'd1);
    check("flicker frame_val", 32'(frame_val), 32'h1834);

    // two strobes low for one cycle: sticky error
    dig_n = 4'b0011;
    seg_n = ~enc(4'h8);
    step(1);
    blank(3);
    check("err_multi set", 32'(err_multi), 32'd1);
    p0 = pulses;
    scan(vecs[0].segs, 4'b0000);
    check("err good frame", 32'(pulses - p0), 32'd1);
    check("err good frame_val", 32'(frame_val), 32'h3017);
    check("err_multi sticky", 32'(err_multi), 32'd1);

    // timeout: partial frame, long blank, then partial must not combine
    p0 = pulses;
    drive(1, enc(4'h1), 1'b0, 8);
    drive(2, enc(4'h2), 1'b0, 8);
    blank(4000);
    check("disp_off early", 32'(disp_off), 32'd0);
    step(110);
    check("disp_off set", 32'(disp_off), 32'd1);
    check("timeout no frame", 32'(pulses - p0), 32'd0);
    check("timeout frame_val held", 32'(frame_val), 32'h3017);
    drive(3, enc(4'h5), 1'b0, 8);
    drive(4, enc(4'h5), 1'b0, 8);
    check("partial discarded", 32'(pulses - p0), 32'd0);
    check("disp_off cleared", 32'(disp_off), 32'd0);
    drive(1, enc(4'h5), 1'b0, 8);
    drive(2, enc(4'h5), 1'b0, 8);
    blank(2);
    check("after timeout frame", 32'(pulses - p0), 32'd1);
    check("after timeout frame_val", 32'(frame_val), 32'h5555);

    // reset while settling digit3 with digits 1,2 already captured
    drive(1, enc(4'h9), 1'b0, 8);
    drive(2, enc(4'h6), 1'b0, 8);
    drive(3, enc(4'h4), 1'b0, 3);
    rst = 1'b1;
    #2;
    check("midrst frame_val", 32'(frame_val), 32'h0);
    check("midrst bad_mask", 32'(bad_mask), 32'h0);
    check("midrst err_multi", 32'(err_multi), 32'd0);
    check("midrst disp_off", 32'(disp_off), 32'd0);
    check("midrst frame_valid", 32'(frame_valid), 32'd0);
    step(1);
    rst = 1'b0;
    blank(2);
    p0 = pulses;
    drive(3, enc(4'h4), 1'b0, 8);
    drive(4, enc(4'h2), 1'b0, 8);
    drive(1, enc(4'h1), 1'b0, 8);
    drive(2, enc(4'h2), 1'b0, 8);
    blank(2);
    check("post-rst one frame", 32'(pulses - p0), 32'd1);
    check("post-rst frame_val", 32'(frame_val), 32'h1242);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
